io_input_capture: RTL
=====================

Name: io_input_capture

Overview:
- Front end of the DMA input queue.
- Synchronises and debounces the board "apply" push-button, samples the 22-bit switch bus on each clean press, and buffers the samples in a show-ahead FIFO.
- The DMA's RI/RAI/PAUSE handling pops entries through rd_en and reads count for GIA.
- Replaces raw button-edge clocking with a single-clock, glitch-free path.

Parameters:
- DATA_W, 22, width of one captured input word.
- DEPTH_LOG2, 5, FIFO depth = 2**DEPTH_LOG2 (32 entries).
- DEBOUNCE_CYCLES, 50000, consecutive stable clock cycles required to accept a button level change (minimum 2).

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- apply_btn_n  in  1  raw push-button, active-low (0 = pressed), asynchronous to clock.
- io_in  in  DATA_W  raw switch bus, asynchronous to clock.
- clr  in  1  synchronous flush of FIFO contents and overflow flag.
- rd_en  in  1  pop request; honoured only when empty=0.
- rd_data  out  DATA_W  head entry (show-ahead); 0 when empty.
- count  out  DEPTH_LOG2+1  entries held (0..32).
- empty  out  1  count==0.
- full  out  1  count==2**DEPTH_LOG2.
- push_pulse  out  1  one-cycle strobe on the cycle an entry is written.
- overflow  out  1  sticky; set when a press is dropped because the FIFO is full.

Behaviour:
- Reset values:
  - rd_data=0, count=0, empty=1, full=0, push_pulse=0, overflow=0.
  - Write and read pointers = 0; FSM = RELEASED.
  - Synchroniser flops = 1 for the button and 0 for the data bus; debounce counter = 0.
- Synchronisation: apply_btn_n passes through a 2-flop synchroniser giving btn_s; io_in passes through a 2-flop register giving io_s.
- Debounce FSM (counter width sized from DEBOUNCE_CYCLES):
  - RELEASED: btn_s=0 -> DEB_PRESS, counter=0.
  - DEB_PRESS:
    - btn_s=1 -> RELEASED.
    - Otherwise counter++; when counter reaches DEBOUNCE_CYCLES-1 -> PRESSED and issue push.
  - PRESSED: btn_s=1 -> DEB_RELEASE, counter=0.
  - DEB_RELEASE:
    - btn_s=0 -> PRESSED.
    - Otherwise counter++; when counter reaches DEBOUNCE_CYCLES-1 -> RELEASED.
  - Exactly one push per press, however long the button is held or however much it bounces.
- Push:
  - Writes io_s of that cycle to mem[wr_ptr], increments wr_ptr (mod 32) and pulses push_pulse.
  - Latency from a clean apply_btn_n fall to push_pulse = 2 + DEBOUNCE_CYCLES cycles.
  - Entry visible on rd_data/count the cycle after push_pulse.
- Pop: rd_en && !empty -> rd_ptr++ (mod 32); the new head appears on rd_data the next cycle. rd_en while empty is ignored, with no pointer or count change.
- Simultaneous push and pop:
  - Both take effect; count unchanged.
  - This holds when full: the push is accepted, no overflow.
  - When empty: the pop is ignored, the push is accepted, count becomes 1.
- Push while full without pop: data dropped, pointers and count unchanged, overflow<=1, push_pulse stays 0.
- clr:
  - Pointers=0, count=0, overflow=0; the debounce FSM is unaffected.
  - clr has priority over push and pop in the same cycle; that push is lost and does not set overflow.
- Pointer wrap: pointers are DEPTH_LOG2 bits and wrap naturally; count is tracked explicitly, not derived from pointer difference.
- Reset mid-operation: everything returns to reset values immediately. A button held across reset deassertion produces a push only after it is released and pressed again: the synchroniser resets to 1 and the FSM must see btn_s=0 from RELEASED.

Test Plan:
- Bench DEBOUNCE_CYCLES=4. reset pulse, then io_in=22'h0ABCDE, apply_btn_n low for 20 cycles -> push_pulse exactly once, 6 cycles after the fall; then rd_data=22'h0ABCDE, count=1, empty=0.
- Bounce: apply_btn_n toggles 0/1 every 2 cycles for 12 cycles, then holds 0 -> no push during the toggling; a single push after 6 stable cycles.
- Fill: 32 clean presses with io_in=i -> count=32, full=1. 33rd press -> overflow=1, count=32. Pop 32 times -> rd_data sequence 0..31, then empty=1, rd_data=0.
- Wrap and concurrency: hold count=5 with pointers near 31. Issue a press and rd_en in the same cycle -> count stays 5, FIFO order preserved across the index 31->0 wrap. A pop on empty -> no change.
- Full plus simultaneous pop: count=32, a push coincides with rd_en -> count=32, overflow=0, new data appears 32 pops later.
- clr and reset: assert clr with count=7 and overflow=1 -> count=0, overflow=0 next cycle. Assert reset while in DEB_PRESS with the button held, deassert -> no push until the button is released and pressed again.

Source files
------------

// File: rtl/io_input_capture_if.sv
// Bus bundle for io_input_capture: raw button and switch inputs, FIFO read
// side and status. The slave modport is the capture block's view; the master
// modport is the view of whatever drives the inputs and pops entries.
interface io_input_capture_if #(
    parameter int DATA_W     = 22,
    parameter int DEPTH_LOG2 = 5
);
    logic                  apply_btn_n;
    logic [DATA_W-1:0]     io_in;
    logic                  clr;
    logic                  rd_en;
    logic [DATA_W-1:0]     rd_data;
    logic [DEPTH_LOG2:0]   count;
    logic                  empty;
    logic                  full;
    logic                  push_pulse;
    logic                  overflow;

    modport slave (
        input  apply_btn_n, io_in, clr, rd_en,
        output rd_data, count, empty, full, push_pulse, overflow
    );

    modport master (
        output apply_btn_n, io_in, clr, rd_en,
        input  rd_data, count, empty, full, push_pulse, overflow
    );
endinterface

// File: rtl/io_input_capture.sv
// Input capture front end: synchronises and debounces the active-low apply
// button, samples the synchronised switch bus once per clean press and queues
// the samples in a show-ahead FIFO.
//
// state       | meaning
// RELEASED    | button idle; waiting for btn_s=0 (only once armed)
// DEB_PRESS   | button low, counting stable cycles before accepting press
// PRESSED     | press accepted; waiting for btn_s=1
// DEB_RELEASE | button high, counting stable cycles before accepting release
module io_input_capture #(
    parameter int DATA_W          = 22,
    parameter int DEPTH_LOG2      = 5,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                clock,
    input  logic                reset,
    io_input_capture_if.slave   bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    // Counter value whose increment reaches DEBOUNCE_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    typedef enum logic [1:0] {RELEASED, DEB_PRESS, PRESSED, DEB_RELEASE} state_t;

    logic [1:0]            btn_sync;
    logic                  btn_s;
    logic [DATA_W-1:0]     io_m;
    logic [DATA_W-1:0]     io_s;

    state_t                state;
    logic [CNT_W-1:0]      deb_cnt;
    logic                  push_req;
    logic [1:0]            fill;
    logic                  armed;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   cnt_q;
    logic                  overflow_q;
    logic                  empty_i;
    logic                  full_i;
    logic                  pop;
    logic                  push_ok;

    assign btn_s = btn_sync[1];

    // Two-flop synchronisers for the button and the switch bus.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            btn_sync <= 2'b11;
            io_m     <= '0;
            io_s     <= '0;
        end else begin
            btn_sync <= {btn_sync[0], bus.apply_btn_n};
            io_m     <= bus.io_in;
            io_s     <= io_m;
        end
    end

    // Debounce FSM. The synchroniser resets to "released", so the first two
    // btn_s values after reset are not real samples; the FSM only arms once
    // a genuine released level has been seen, which keeps a button held
    // across reset from producing a push.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= RELEASED;
            deb_cnt  <= '0;
            push_req <= 1'b0;
            fill     <= 2'd0;
            armed    <= 1'b0;
        end else begin
            push_req <= 1'b0;
            if (fill != 2'd2) fill <= fill + 2'd1;
            if (fill == 2'd2 && btn_s) armed <= 1'b1;
            case (state)
                RELEASED: begin
                    if (!btn_s && armed) begin
                        state   <= DEB_PRESS;
                        deb_cnt <= '0;
                    end
                end
                DEB_PRESS: begin
                    if (btn_s) begin
                        state <= RELEASED;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                        if (deb_cnt == CNT_LAST) begin
                            state    <= PRESSED;
                            push_req <= 1'b1;
                        end
                    end
                end
                PRESSED: begin
                    if (btn_s) begin
                        state   <= DEB_RELEASE;
                        deb_cnt <= '0;
                    end
                end
                DEB_RELEASE: begin
                    if (!btn_s) begin
                        state <= PRESSED;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                        if (deb_cnt == CNT_LAST) state <= RELEASED;
                    end
                end
                default: state <= RELEASED;
            endcase
        end
    end

    assign empty_i = (cnt_q == '0);
    assign full_i  = (cnt_q == (DEPTH_LOG2+1)'(DEPTH));
    assign pop     = bus.rd_en && !empty_i && !bus.clr;
    // A push into a full FIFO still fits when a pop frees the head slot.
    assign push_ok = push_req && !bus.clr && (!full_i || pop);

    // FIFO pointers, explicit occupancy count and sticky overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else if (bus.clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (push_req && !push_ok) overflow_q <= 1'b1;
        end
    end

    // Storage array; contents need no reset because rd_data is gated by empty.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= io_s;
    end

    assign bus.rd_data    = empty_i ? '0 : mem[rd_ptr];
    assign bus.count      = cnt_q;
    assign bus.empty      = empty_i;
    assign bus.full       = full_i;
    assign bus.push_pulse = push_ok;
    assign bus.overflow   = overflow_q;
endmodule
